pc_unit: RTL and testbench

//  Parametrised program-counter unit for the 5-stage pipeline. Holds fetch PC,

---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_redirect_arb.sv | 47 ++++
 rtl/pc_unit.sv | 104 ++++++++++
 tb/tb_pc_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch program-counter unit: default vectors,
// the per-fetch increment and the redirect source encoding.
package pc_pkg;

    localparam int unsigned PC_AW_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF  = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF    = 32'h8000_0180;
    localparam int unsigned INC_DEF        = 4;

    // Which request won the redirect arbitration this cycle.
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_EXC  = 3'd1,
        SRC_ERET = 3'd2,
        SRC_BR   = 3'd3,
        SRC_JMP  = 3'd4
    } redir_src_t;

    // Word-alignment test on the two low address bits.
    function automatic logic low_bits_set(input logic [1:0] addr_lo);
        return |addr_lo;
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational priority encoder for PC redirect requests.
// Priority: exception > ERET > branch > jump. ERET targets the saved EPC.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int unsigned   AW      = PC_AW_DEF,
    parameter logic [AW-1:0] EXC_VEC = AW'(EXC_VEC_DEF)
) (
    input  logic          exc_en,
    input  logic          eret_en,
    input  logic [AW-1:0] epc,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    input  logic          jump_en,
    input  logic [AW-1:0] jump_target,
    output logic          redir_valid,
    output redir_src_t    redir_src,
    output logic [AW-1:0] redir_target
);

    // Pick the highest-priority live request and its target address.
    always_comb begin
        // NOTE: every output gets a default before the if-chain so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        redir_valid  = 1'b0;
        redir_src    = SRC_NONE;
        redir_target = '0;
        if (exc_en) begin
            redir_valid  = 1'b1;
            redir_src    = SRC_EXC;
            redir_target = EXC_VEC;
        end else if (eret_en) begin
            redir_valid  = 1'b1;
            redir_src    = SRC_ERET;
            redir_target = epc;
        end else if (branch_taken) begin
            redir_valid  = 1'b1;
            redir_src    = SRC_BR;
            redir_target = branch_target;
        end else if (jump_en) begin
            redir_valid  = 1'b1;
            redir_src    = SRC_JMP;
            redir_target = jump_target;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter for the 5-stage pipeline. Advances by INC per
// cycle, redirects on exception/ERET/branch/jump, and parks one redirect
// while the pipeline is stalled so it is applied on stall release.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned   AW        = PC_AW_DEF,
    parameter logic [AW-1:0] RESET_VEC = AW'(RESET_VEC_DEF),
    parameter logic [AW-1:0] EXC_VEC   = AW'(EXC_VEC_DEF),
    parameter int unsigned   INC       = INC_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Stall,
    input  logic          ExcEn,
    input  logic [AW-1:0] ExcPC,
    input  logic          EretEn,
    input  logic          BranchTaken,
    input  logic [AW-1:0] BranchTarget,
    input  logic          JumpEn,
    input  logic [AW-1:0] JumpTarget,
    output logic [AW-1:0] PCResult,
    output logic [AW-1:0] PCPlusInc,
    output logic [AW-1:0] EPC,
    output logic          RedirPending,
    output logic          Misaligned
);

    logic          redir_valid;
    redir_src_t    redir_src;
    logic [AW-1:0] redir_target;

    logic [AW-1:0] pend_target;
    logic [AW-1:0] pc_next;
    logic [AW-1:0] epc_next;
    logic          pend_next;
    logic [AW-1:0] pend_target_next;

    pc_redirect_arb #(
        .AW      (AW),
        .EXC_VEC (EXC_VEC)
    ) u_arb (
        .exc_en        (ExcEn),
        .eret_en       (EretEn),
        .epc           (EPC),
        .branch_taken  (BranchTaken),
        .branch_target (BranchTarget),
        .jump_en       (JumpEn),
        .jump_target   (JumpTarget),
        .redir_valid   (redir_valid),
        .redir_src     (redir_src),
        .redir_target  (redir_target)
    );

    // Sequential increment wraps naturally at 2^AW; alignment is flag-only.
    assign PCPlusInc  = PCResult + AW'(INC);
    assign Misaligned = low_bits_set(PCResult[1:0]);

    // Next-state selection for PC, EPC and the one-deep parked redirect.
    always_comb begin
        pc_next          = PCResult;
        epc_next         = EPC;
        pend_next        = RedirPending;
        pend_target_next = pend_target;
        if (redir_src == SRC_EXC) begin
            // Exceptions bypass the stall and drop anything parked.
            pc_next   = redir_target;
            epc_next  = ExcPC;
            pend_next = 1'b0;
        end else if (!Stall) begin
            // A live request supersedes the parked one; the buffer drains either way.
            if (redir_valid) begin
                pc_next = redir_target;
            end else if (RedirPending) begin
                pc_next = pend_target;
            end else begin
                pc_next = PCPlusInc;
            end
            pend_next = 1'b0;
        end else if (redir_valid) begin
            // Stalled: hold PC, park the winner (newer request overwrites older).
            pend_next        = 1'b1;
            pend_target_next = redir_target;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (Reset) begin
            PCResult     <= RESET_VEC;
            EPC          <= '0;
            RedirPending <= 1'b0;
            pend_target  <= '0;
        end else begin
            PCResult     <= pc_next;
            EPC          <= epc_next;
            RedirPending <= pend_next;
            pend_target  <= pend_target_next;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit: a table of cycle-by-cycle vectors with
// hand-computed expectations, plus hand-written reset and alignment sequences.
module tb_pc_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Stall = 1'b0;
    logic        ExcEn = 1'b0;
    logic [31:0] ExcPC = '0;
    logic        EretEn = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        JumpEn = 1'b0;
    logic [31:0] JumpTarget = '0;

    logic [31:0] PCResult, PCPlusInc, EPC;
    logic        RedirPending, Misaligned;
    logic [31:0] PCResult2, PCPlusInc2, EPC2;
    logic        RedirPending2, Misaligned2;

    int checks   = 0;
    int failures = 0;

    pc_unit dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .ExcEn(ExcEn), .ExcPC(ExcPC),
        .EretEn(EretEn), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .JumpEn(JumpEn), .JumpTarget(JumpTarget), .PCResult(PCResult),
        .PCPlusInc(PCPlusInc), .EPC(EPC), .RedirPending(RedirPending),
        .Misaligned(Misaligned)
    );

    // Second instance with a misaligned reset vector.
    pc_unit #(.RESET_VEC(32'h1)) dut_mis (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .ExcEn(ExcEn), .ExcPC(ExcPC),
        .EretEn(EretEn), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .JumpEn(JumpEn), .JumpTarget(JumpTarget), .PCResult(PCResult2),
        .PCPlusInc(PCPlusInc2), .EPC(EPC2), .RedirPending(RedirPending2),
        .Misaligned(Misaligned2)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        exc;
        logic [31:0] exc_pc;
        logic        eret;
        logic        br;
        logic [31:0] br_t;
        logic        jmp;
        logic [31:0] jmp_t;
        logic [31:0] exp_pc;
        logic [31:0] exp_epc;
        logic        exp_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic ex, logic [31:0] expc, logic er,
                                logic b, logic [31:0] bt, logic j, logic [31:0] jt,
                                logic [31:0] epc_v, logic [31:0] eepc, logic epend);
        vec_t v;
        v.stall = st; v.exc = ex; v.exc_pc = expc; v.eret = er;
        v.br = b; v.br_t = bt; v.jmp = j; v.jmp_t = jt;
        v.exp_pc = epc_v; v.exp_epc = eepc; v.exp_pend = epend;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        Stall = v.stall; ExcEn = v.exc; ExcPC = v.exc_pc; EretEn = v.eret;
        BranchTaken = v.br; BranchTarget = v.br_t; JumpEn = v.jmp; JumpTarget = v.jmp_t;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        //          st ex exc_pc        er br br_t          jm jmp_t         pc            epc    pend
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,          0, 0,            32'h4,        0,     0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,          0, 0,            32'h8,        0,     0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,          0, 0,            32'hC,        0,     0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,          1, 32'h10,       32'h10,       0,     0));
        vecs.push_back(mk(1, 0, 0,     0, 0, 0,          0, 0,            32'h10,       0,     0));
        vecs.push_back(mk(1, 0, 0,     0, 0, 0,          0, 0,            32'h10,       0,     0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,          0, 0,            32'h14,       0,     0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,          1, 32'h20,       32'h20,       0,     0));
        vecs.push_back(mk(0, 0, 0,     0, 1, 32'h100,    1, 32'h200,      32'h100,      0,     0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,          1, 32'h30,       32'h30,       0,     0));
        vecs.push_back(mk(1, 0, 0,     0, 1, 32'h300,    0, 0,            32'h30,       0,     1));
        vecs.push_back(mk(1, 0, 0,     0, 0, 0,          1, 32'h400,      32'h30,       0,     1));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,          0, 0,            32'h400,      0,     0));
        vecs.push_back(mk(1, 0, 0,     0, 0, 0,          1, 32'h500,      32'h400,      0,     1));
        vecs.push_back(mk(1, 1, 32'h44, 0, 0, 0,         0, 0,            32'h80000180, 32'h44, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,          0, 0,            32'h80000184, 32'h44, 0));
        vecs.push_back(mk(0, 0, 0,     1, 0, 0,          0, 0,            32'h44,       32'h44, 0));
        vecs.push_back(mk(1, 0, 0,     1, 0, 0,          0, 0,            32'h44,       32'h44, 1));
        vecs.push_back(mk(0, 0, 0,     0, 1, 32'h600,    0, 0,            32'h600,      32'h44, 0));
        vecs.push_back(mk(1, 0, 0,     0, 0, 0,          1, 32'h700,      32'h600,      32'h44, 1));
        vecs.push_back(mk(0, 0, 0,     1, 0, 0,          0, 0,            32'h44,       32'h44, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,          0, 0,            32'h48,       32'h44, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,          1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h44, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,          0, 0,            32'h0,        32'h44, 0));
        vecs.push_back(mk(1, 0, 0,     0, 0, 0,          0, 0,            32'h0,        32'h44, 0));
        vecs.push_back(mk(0, 0, 0,     0, 0, 0,          1, 32'h2,        32'h2,        32'h44, 0));
        vecs.push_back(mk(0, 1, 32'h88, 1, 1, 32'h900,   1, 32'hA00,      32'h80000180, 32'h88, 0));
        vecs.push_back(mk(0, 0, 0,     1, 0, 0,          0, 0,            32'h88,       32'h88, 0));

        // Power-on reset, checked before any clock edge.
        #1 Reset = 1'b1;
        #2;
        check("por_pc", PCResult, 32'h0);
        check("por_epc", EPC, 32'h0);
        check("por_pend", {31'b0, RedirPending}, 32'h0);
        check("por_pcplus", PCPlusInc, 32'h4);
        check("por_mis", {31'b0, Misaligned}, 32'h0);
        check("mis_inst_pc", PCResult2, 32'h1);
        check("mis_inst_flag", {31'b0, Misaligned2}, 32'h1);
        check("mis_inst_pcplus", PCPlusInc2, 32'h5);
        @(negedge Clk);
        Reset = 1'b0;

        // Table-driven run.
        foreach (vecs[i]) begin
            drive(vecs[i]);
            step();
            check($sformatf("v%0d_pc", i), PCResult, vecs[i].exp_pc);
            check($sformatf("v%0d_epc", i), EPC, vecs[i].exp_epc);
            check($sformatf("v%0d_pend", i), {31'b0, RedirPending}, {31'b0, vecs[i].exp_pend});
            check($sformatf("v%0d_pcplus", i), PCPlusInc, vecs[i].exp_pc + 32'd4);
            check($sformatf("v%0d_mis", i), {31'b0, Misaligned}, {31'b0, (vecs[i].exp_pc[1:0] != 2'b00)});
        end

        // Mid-run asynchronous reset at PC=0x40 with a redirect parked.
        drive(mk(0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0, 0));
        step();
        check("pre_rst_pc", PCResult, 32'h40);
        drive(mk(1, 0, 0, 0, 0, 0, 1, 32'h99C, 0, 0, 0));
        step();
        check("pre_rst_pend", {31'b0, RedirPending}, 32'h1);
        idle();
        #2 Reset = 1'b1;
        #1;
        check("async_rst_pc", PCResult, 32'h0);
        check("async_rst_epc", EPC, 32'h0);
        check("async_rst_pend", {31'b0, RedirPending}, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        step();
        check("post_rst_e1", PCResult, 32'h4);
        step();
        check("post_rst_e2", PCResult, 32'h8);
        step();
        check("post_rst_e3", PCResult, 32'hC);
        check("post_rst_pend", {31'b0, RedirPending}, 32'h0);

        // Exception while stalled with nothing else active, then ERET keeps EPC.
        drive(mk(1, 0, 0, 0, 1, 32'h123C, 0, 0, 0, 0, 0));
        step();
        drive(mk(1, 1, 32'h5C, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        check("exc_stall_pc", PCResult, 32'h80000180);
        check("exc_stall_epc", EPC, 32'h5C);
        check("exc_stall_pend", {31'b0, RedirPending}, 32'h0);
        idle();
        step();
        check("exc_no_replay", PCResult, 32'h80000184);
        drive(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        step();
        check("eret_pc", PCResult, 32'h5C);
        check("eret_epc", EPC, 32'h5C);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
